// File: rtl/instr_pkg.sv
// instr_pkg: widths, types and FSM states shared by the instruction RAM loader.
package instr_pkg;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 7;
  localparam int DEPTH = 128;
  typedef logic [DATA_W-1:0] instr_t;
  typedef logic [ADDR_W-1:0] iaddr_t;
  typedef logic [ADDR_W:0] icnt_t;
  typedef enum logic [1:0] {IDLE, LOAD, DONE} loader_state_t;
  function automatic logic len_ok(icnt_t len);
    return len != '0 && len <= icnt_t'(DEPTH);
  endfunction
endpackage

// File: rtl/instr_ram.sv
// instr_ram: 1-write/1-read synchronous RAM, registered read, read-before-write.
module instr_ram
  import instr_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   we,
  input  iaddr_t wr_addr,
  input  instr_t wr_data,
  input  iaddr_t rd_addr,
  output instr_t rd_data
);
  instr_t mem [DEPTH];
  instr_t rd_data_d, rd_data_q;
  always_comb rd_data_d = mem[rd_addr];
  // Array has no reset so it maps onto block RAM; only the output register resets.
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data_q <= '0;
    else rd_data_q <= rd_data_d;
  end
  assign rd_data = rd_data_q;
endmodule

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: streams instruction words over valid/ready into instr_ram
// and exposes a one-clock registered read port for the fetch sequencer.
module instr_mem_loader
  import instr_pkg::*;
(
  input  logic              Clk,
  input  logic              ResetN,
  input  logic              Start,
  input  logic [ADDR_W:0]   Len,
  input  logic              Abort,
  input  logic              In_Valid,
  input  logic [DATA_W-1:0] In_Data,
  output logic              In_Ready,
  input  logic [ADDR_W-1:0] Rd_Addr,
  output logic [DATA_W-1:0] Rd_Data,
  output logic              Busy,
  output logic              Done,
  output logic              Err,
  output logic [ADDR_W:0]   Wr_Count
);
  loader_state_t state_q, state_d;
  iaddr_t addr_q, addr_d;
  icnt_t cnt_q, cnt_d, len_q, len_d;
  logic err_q, err_d, xfer;
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    cnt_d = cnt_q;
    len_d = len_q;
    err_d = 1'b0;
    xfer = state_q == LOAD && In_Valid;
    case (state_q)
      IDLE: if (Start) begin
        if (len_ok(Len)) begin
          state_d = LOAD;
          len_d = Len;
          addr_d = '0;
          cnt_d = '0;
        end else err_d = 1'b1;
      end
      LOAD: begin
        addr_d = xfer ? addr_q + 1'b1 : addr_q;
        cnt_d = xfer ? cnt_q + 1'b1 : cnt_q;
        // Abort still keeps a word handshaken in the same cycle, but suppresses Done.
        state_d = Abort ? IDLE : (xfer && cnt_d == len_q) ? DONE : LOAD;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state_q <= IDLE;
      addr_q <= '0;
      cnt_q <= '0;
      len_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      cnt_q <= cnt_d;
      len_q <= len_d;
      err_q <= err_d;
    end
  end
  assign In_Ready = state_q == LOAD;
  assign Busy = state_q == LOAD;
  assign Done = state_q == DONE;
  assign Err = err_q;
  assign Wr_Count = cnt_q;
  instr_ram u_ram (
    .clk     (Clk),
    .rst_n   (ResetN),
    .we      (xfer),
    .wr_addr (addr_q),
    .wr_data (In_Data),
    .rd_addr (Rd_Addr),
    .rd_data (Rd_Data)
  );
endmodule
